axi_wr_data_fifo: RTL and testbench

// - Buffered, burst-aware AXI write-data (W) channel stage between a W-channel master and slave.
// - A burst-length command (AWLEN) arms a beat counter; beats are buffered in a DEPTH-entry FIFO.
// - m_wlast is regenerated from the counter, independent of the incoming wlast.
// - Incoming s_wlast is optionally checked against the count.

---
 rtl/axi_wr_data_fifo.sv | 165 ++++++++++++++++
 tb/tb_axi_wr_data_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_data_fifo.sv
// axi_wr_data_fifo
// Burst-aware AXI write-data (W) channel buffer. A burst command (AWLEN)
// arms a beat counter. Accepted beats are stored in a DEPTH-entry FIFO
// together with a regenerated last flag. The incoming s_wlast is not used to
// build m_wlast.
// Optional feature macro: AXI_W_LAST_CHECK_EN. When it is defined, a mismatch
// between s_wlast and the regenerated last flag sets the sticky err_wlast.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. Once a producer raises valid, it holds the payload until that
// edge. s_wready depends only on the FSM state and FIFO fullness. It never
// depends on m_wready. cmd_ready depends only on the FSM state.
module axi_wr_data_fifo #(
    parameter int ID_MAX_WIDTH = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [LEN_WIDTH-1:0]         cmd_len,
    input  logic                         s_wvalid,
    output logic                         s_wready,
    input  logic [ID_MAX_WIDTH-1:0]      s_wid,
    input  logic [DATA_WIDTH-1:0]        s_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_wstrb,
    input  logic                         s_wlast,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    output logic [ID_MAX_WIDTH-1:0]      m_wid,
    output logic [DATA_WIDTH-1:0]        m_wdata,
    output logic [DATA_WIDTH/8-1:0]      m_wstrb,
    output logic                         m_wlast,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic                         err_wlast,
    input  logic                         err_clr
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int LVL_WIDTH   = $clog2(DEPTH + 1);
    localparam int ENTRY_WIDTH = ID_MAX_WIDTH + DATA_WIDTH + STRB_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // The FSM state is kept in a named register so checkers can bind to it.
    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    beats_left_q, beats_left_d;

    logic [ENTRY_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr, rd_ptr;
    logic [LVL_WIDTH-1:0]    level;

    logic full, empty, push, pop, gen_last;

    assign full     = (level == LVL_WIDTH'(DEPTH));
    assign empty    = (level == '0);
    assign gen_last = (beats_left_q == '0);
    assign push     = s_wvalid & s_wready;
    assign pop      = m_wvalid & m_wready;

    // FSM state and beat counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Next-state logic. Commands are taken only in IDLE, and beats only in
    // BURST. The burst ends on the beat where the counter reaches zero.
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        cmd_ready    = 1'b0;
        s_wready     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    beats_left_d = cmd_len;
                    state_d      = BURST;
                end
            end
            BURST: begin
                s_wready = !full;
                if (s_wvalid && !full) begin
                    if (gen_last) begin
                        state_d = IDLE;
                    end else begin
                        beats_left_d = beats_left_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage. It is cleared on reset, so the head outputs read zero
    // while the FIFO is empty after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {s_wid, s_wdata, s_wstrb, gen_last};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The level
    // tracks occupancy, and a simultaneous push and pop leave it unchanged.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_WIDTH'(1);
                2'b01:   level <= level - LVL_WIDTH'(1);
                default: level <= level;
            endcase
        end
    end

    assign m_wvalid   = !empty;
    assign fifo_level = level;
    assign {m_wid, m_wdata, m_wstrb, m_wlast} = mem[rd_ptr];

`ifdef AXI_W_LAST_CHECK_EN
    // Sticky wlast mismatch flag. A new mismatch wins over a same-cycle clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_wlast <= 1'b0;
        end else if (push && (s_wlast != gen_last)) begin
            err_wlast <= 1'b1;
        end else if (err_clr) begin
            err_wlast <= 1'b0;
        end
    end
`else
    // Checking is disabled, so s_wlast and err_clr have no effect.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_wlast, err_clr};
    assign err_wlast = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_data_fifo.sv
// tb_axi_wr_data_fifo
// Directed bench for axi_wr_data_fifo. Expected beats are queued when they
// are pushed and compared in order as they leave the master side.
module tb_axi_wr_data_fifo;

  localparam int ID_W  = 12;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int LW    = 8;
  localparam int DEPTH = 4;
  localparam int LVW   = $clog2(DEPTH + 1);
  localparam int EW    = ID_W + DW + SW + 1;

`ifdef AXI_W_LAST_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic            cmd_valid, cmd_ready;
  logic [LW-1:0]   cmd_len;
  logic            s_wvalid, s_wready;
  logic [ID_W-1:0] s_wid;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_wlast;
  logic            m_wvalid, m_wready;
  logic [ID_W-1:0] m_wid;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wlast;
  logic [LVW-1:0]  fifo_level;
  logic            err_wlast, err_clr;

  axi_wr_data_fifo #(
    .ID_MAX_WIDTH (ID_W),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .LEN_WIDTH    (LW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_wid      (s_wid),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_wlast    (s_wlast),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_wid      (m_wid),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wlast    (m_wlast),
    .fifo_level (fifo_level),
    .err_wlast  (err_wlast),
    .err_clr    (err_clr)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every beat that leaves on the master side against the queue head.
  always @(negedge aclk) begin
    if (mon_en && aresetn && m_wvalid && m_wready) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        check("beat", {m_wid, m_wdata, m_wstrb, m_wlast}, exp_q.pop_front());
        n_out++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    int waited;
    waited = 0;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 64) begin
      step;
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [ID_W-1:0] id, input logic [DW-1:0] d,
                           input logic [SW-1:0] st, input logic wl, input logic el);
    int waited;
    waited = 0;
    s_wvalid = 1'b1;
    s_wid    = id;
    s_wdata  = d;
    s_wstrb  = st;
    s_wlast  = wl;
    while (!s_wready && waited < 64) begin
      step;
      waited++;
    end
    if (!s_wready) begin
      check("s_wready_timeout", 64'(s_wready), 64'd1);
      s_wvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    exp_q.push_back({id, d, st, el});
    #1;
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
  endtask

  task automatic wait_drain;
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 600) begin
      step;
      waited++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmd_valid = 0; cmd_len = '0; s_wvalid = 0; s_wid = '0; s_wdata = '0;
    s_wstrb = '0; s_wlast = 0; m_wready = 0; err_clr = 0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_len   = LW'($urandom_range(0, 255));
      s_wvalid  = 1'($urandom_range(0, 1));
      s_wdata   = $urandom;
      s_wlast   = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      err_clr   = 1'($urandom_range(0, 1));
      @(negedge aclk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_s_wready", 64'(s_wready), 64'd0);
      check("rst_m_wvalid", 64'(m_wvalid), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_err", 64'(err_wlast), 64'd0);
      check("rst_m_payload", {m_wid, m_wdata, m_wstrb, m_wlast}, 64'd0);
    end
    cmd_valid = 0; cmd_len = '0; s_wvalid = 0; s_wdata = '0; s_wlast = 0;
    m_wready = 0; err_clr = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    step;
    mon_en = 1'b1;

    // Basic burst: 4 beats, last flag only on the 4th
    m_wready = 1'b1;
    check("basic_idle_m_wvalid", 64'(m_wvalid), 64'd0);
    send_cmd(8'd3);
    check("basic_cmd_ready_burst", 64'(cmd_ready), 64'd0);
    check("basic_s_wready", 64'(s_wready), 64'd1);
    push_beat(12'h001, 32'hA000_0000, 4'hF, 1'b0, 1'b0);
    check("basic_latency_m_wvalid", 64'(m_wvalid), 64'd1);
    push_beat(12'h002, 32'hA000_0001, 4'h3, 1'b0, 1'b0);
    push_beat(12'h003, 32'hA000_0002, 4'hC, 1'b0, 1'b0);
    push_beat(12'h004, 32'hA000_0003, 4'h1, 1'b1, 1'b1);
    check("basic_back_idle", 64'(cmd_ready), 64'd1);
    wait_drain;
    check("basic_n_out", 64'(n_out), 64'd4);
    check("basic_err", 64'(err_wlast), 64'd0);
    check("basic_level", 64'(fifo_level), 64'd0);

    // Backpressure: fill 4 of 8, then drain everything
    m_wready = 1'b0;
    send_cmd(8'd7);
    for (int i = 0; i < 4; i++) begin
      push_beat(12'h010 + 12'(i), 32'h0000_0100 + 32'(i), 4'hF, 1'b0, 1'b0);
    end
    check("bp_level_full", 64'(fifo_level), 64'd4);
    check("bp_s_wready_full", 64'(s_wready), 64'd0);
    check("bp_head_data", 64'(m_wdata), 64'h100);
    step;
    step;
    check("bp_head_stable", 64'(m_wdata), 64'h100);
    check("bp_level_hold", 64'(fifo_level), 64'd4);
    m_wready = 1'b1;
    #1;
    check("bp_full_pop_no_ready", 64'(s_wready), 64'd0);
    for (int i = 4; i < 8; i++) begin
      push_beat(12'h010 + 12'(i), 32'h0000_0100 + 32'(i), 4'hF, i == 7, i == 7);
    end
    wait_drain;
    check("bp_n_out", 64'(n_out), 64'd12);

    // Bad wlast on beat 2, with a same-cycle clear that must lose
    send_cmd(8'd3);
    push_beat(12'h020, 32'hB000_0000, 4'hF, 1'b0, 1'b0);
    check("bad_err_before", 64'(err_wlast), 64'd0);
    err_clr = 1'b1;
    push_beat(12'h021, 32'hB000_0001, 4'hF, 1'b1, 1'b0);
    err_clr = 1'b0;
    check("bad_err_set", 64'(err_wlast), 64'(ERR_ON));
    push_beat(12'h022, 32'hB000_0002, 4'hF, 1'b0, 1'b0);
    push_beat(12'h023, 32'hB000_0003, 4'hF, 1'b0, 1'b1);
    wait_drain;
    step;
    step;
    check("bad_err_sticky", 64'(err_wlast), 64'(ERR_ON));
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    check("bad_err_cleared", 64'(err_wlast), 64'd0);
    check("bad_n_out", 64'(n_out), 64'd16);

    // Command gating with cmd_valid held high
    cmd_len   = 8'd0;
    cmd_valid = 1'b1;
    check("gate_ready_idle", 64'(cmd_ready), 64'd1);
    step;
    check("gate_ready_burst", 64'(cmd_ready), 64'd0);
    s_wvalid = 1'b1; s_wid = 12'h030; s_wdata = 32'hC0C0_0001; s_wstrb = 4'hA; s_wlast = 1'b1;
    exp_q.push_back({12'h030, 32'hC0C0_0001, 4'hA, 1'b1});
    step;
    s_wvalid = 1'b0; s_wlast = 1'b0;
    check("gate_ready_after_beat", 64'(cmd_ready), 64'd1);
    check("gate_s_wready_idle", 64'(s_wready), 64'd0);
    step;
    check("gate_second_taken", 64'(cmd_ready), 64'd0);
    step;
    check("gate_held_in_burst", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    push_beat(12'h031, 32'hC0C0_0002, 4'h5, 1'b1, 1'b1);
    check("gate_idle_again", 64'(cmd_ready), 64'd1);
    wait_drain;
    check("gate_n_out", 64'(n_out), 64'd18);

    // Maximum burst length
    send_cmd(8'd255);
    for (int i = 0; i < 256; i++) begin
      push_beat(12'(i), 32'hD000_0000 + 32'(i), 4'(i), i == 255, i == 255);
    end
    check("max_idle_after", 64'(cmd_ready), 64'd1);
    wait_drain;
    check("max_n_out", 64'(n_out), 64'd274);

    // Reset in the middle of a burst
    m_wready = 1'b0;
    send_cmd(8'd7);
    for (int i = 0; i < 3; i++) begin
      push_beat(12'h040 + 12'(i), 32'hE000_0000 + 32'(i), 4'hF, 1'b0, 1'b0);
    end
    check("mid_level_before", 64'(fifo_level), 64'd3);
    aresetn = 1'b0;
    #1;
    check("mid_level_rst", 64'(fifo_level), 64'd0);
    check("mid_m_wvalid_rst", 64'(m_wvalid), 64'd0);
    check("mid_cmd_ready_rst", 64'(cmd_ready), 64'd1);
    check("mid_s_wready_rst", 64'(s_wready), 64'd0);
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF;
    m_wready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("mid_no_m_wvalid", 64'(m_wvalid), 64'd0);
      check("mid_no_s_wready", 64'(s_wready), 64'd0);
    end
    s_wvalid = 1'b0;
    send_cmd(8'd0);
    push_beat(12'h050, 32'hF000_0001, 4'h9, 1'b1, 1'b1);
    wait_drain;
    check("mid_n_out", 64'(n_out), 64'd275);
    check("mid_level_end", 64'(fifo_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
